pipe_spawner: RTL and testbench

- Consumes the 8-bit pseudo-random byte from the LFSR stage and turns it into obstacle pipes for the flappy-bird playfield.
- Keeps a fixed pool of pipe slots. Spawns a new pipe at the right screen edge every SPAWN_TICKS frame ticks and scrolls all live pipes left by SPEED pixels per tick.
- Retires pipes that leave the screen and pulses/counts when a pipe passes the bird column.
- Outputs feed the collision checker and the VGA renderer.

---
 rtl/pipe_spawner_pkg.sv | 29 ++
 rtl/pipe_spawner_slot.sv | 77 +++++++
 rtl/pipe_spawner.sv | 159 +++++++++++++++
 tb/tb_pipe_spawner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_spawner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_spawner_pkg
// Description : Game state encoding and playfield constants shared by the
//               pipe spawner, collision checker and VGA renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_spawner_pkg;

  // Game state encoding, also exported on the state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  // Playfield geometry.
  localparam int C_X_W       = 10;   // width of x / gap_y coordinates
  localparam int C_SCREEN_W  = 640;  // spawn x (right edge)
  localparam int C_BIRD_X    = 160;  // bird column for pass detection
  localparam int C_GAP_MIN   = 40;   // smallest gap top y

  // Spawner defaults.
  localparam int C_NUM_PIPES   = 4;
  localparam int C_SPEED       = 2;
  localparam int C_SPAWN_TICKS = 90;

endpackage : pipe_spawner_pkg
`default_nettype wire

// File: rtl/pipe_spawner_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One pipe slot: x / gap_y / valid registers with load, scroll
//               and retire logic. Flags when the coming scroll carries the
//               pipe across the bird column.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
  import pipe_spawner_pkg::*;
#(
  parameter int X_W      = C_X_W,
  parameter int SCREEN_W = C_SCREEN_W,
  parameter int SPEED    = C_SPEED,
  parameter int BIRD_X   = C_BIRD_X
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clear,     // empty the slot (new game)
  input  logic           i_scroll,    // frame tick while running
  input  logic           i_load,      // spawn a fresh pipe into this slot
  input  logic [X_W-1:0] i_load_gap,
  output logic [X_W-1:0] o_x,
  output logic [X_W-1:0] o_gap,
  output logic           o_valid,
  output logic           o_pass       // valid only together with i_scroll
);

  localparam logic [X_W-1:0] C_SPEED_V  = X_W'(SPEED);
  localparam logic [X_W-1:0] C_SCREEN_V = X_W'(SCREEN_W);
  localparam logic [X_W-1:0] C_BIRD_V   = X_W'(BIRD_X);

  logic [X_W-1:0] r_x;
  logic [X_W-1:0] r_gap;
  logic           r_valid;

  logic           w_retire;
  logic [X_W-1:0] w_x_next;

  // A pipe closer to the left edge than one step leaves the screen instead of
  // wrapping; its x is held so the renderer keeps a sane value.
  assign w_retire = (r_x < C_SPEED_V);
  assign w_x_next = r_x - C_SPEED_V;

  // Crossing: strictly right of the bird column now, at or left of it after.
  assign o_pass = r_valid && !w_retire && (r_x > C_BIRD_V) && (w_x_next <= C_BIRD_V);

  // Slot registers: clear beats load beats scroll. Load only ever targets an
  // empty slot, so it never competes with a scroll of a live pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_gap   <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_x     <= '0;
      r_gap   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_x     <= C_SCREEN_V;
      r_gap   <= i_load_gap;
      r_valid <= 1'b1;
    end else if (i_scroll && r_valid) begin
      if (w_retire) begin
        r_valid <= 1'b0;
      end else begin
        r_x <= w_x_next;
      end
    end
  end

  assign o_x     = r_x;
  assign o_gap   = r_gap;
  assign o_valid = r_valid;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_spawner.sv
`default_nettype none
// ============================================================================
// Module      : pipe_spawner
// Description : Turns LFSR bytes into scrolling obstacle pipes. Keeps a pool
//               of pipe slots, spawns at the right edge every SPAWN_TICKS
//               frame ticks, scrolls live pipes left, retires off-screen
//               pipes and scores pipes passing the bird column.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_spawner
  import pipe_spawner_pkg::*;
#(
  parameter int NUM_PIPES   = C_NUM_PIPES,
  parameter int X_W         = C_X_W,
  parameter int SCREEN_W    = C_SCREEN_W,
  parameter int SPEED       = C_SPEED,
  parameter int SPAWN_TICKS = C_SPAWN_TICKS,
  parameter int BIRD_X      = C_BIRD_X,
  parameter int GAP_MIN     = C_GAP_MIN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_enable,
  input  logic                     i_tick,
  input  logic                     i_start,
  input  logic                     i_crash,
  input  logic [7:0]               i_rnd,
  output logic [NUM_PIPES*X_W-1:0] o_pipe_x,
  output logic [NUM_PIPES*X_W-1:0] o_gap_y,
  output logic [NUM_PIPES-1:0]     o_pipe_valid,
  output logic                     o_pass_pulse,
  output logic                     o_spawn_drop,
  output logic [7:0]               o_score,
  output logic [1:0]               o_state
);

  localparam int                 C_CNT_W    = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(SPAWN_TICKS - 1);

  state_t               r_state;
  logic [C_CNT_W-1:0]   r_spawn_cnt;
  logic [7:0]           r_score;
  logic                 r_pass_pulse;
  logic                 r_spawn_drop;

  logic                 w_enter_run;
  logic                 w_run_tick;
  logic                 w_spawn;
  logic                 w_any_pass;
  logic                 w_any_free;
  logic [NUM_PIPES-1:0] w_valid;
  logic [NUM_PIPES-1:0] w_pass;
  logic [NUM_PIPES-1:0] w_free;
  logic [NUM_PIPES-1:0] w_sel;
  logic [NUM_PIPES-1:0] w_load;
  logic [X_W-1:0]       w_new_gap;

  // Event qualification. With enable low every event is ignored. A crash in
  // RUN suppresses both a same-cycle tick and a same-cycle start.
  assign w_enter_run = i_enable && i_start &&
                       ((r_state == ST_IDLE) || (r_state == ST_FROZEN));
  assign w_run_tick  = i_enable && (r_state == ST_RUN) && i_tick && !i_crash;
  assign w_spawn     = w_run_tick && (r_spawn_cnt == C_CNT_LAST);

  // Free-slot priority encoder: isolate the lowest empty slot as a one-hot.
  // Uses validity from before this tick, so a slot retiring on the same tick
  // cannot be refilled until the next spawn.
  assign w_free     = ~w_valid;
  assign w_sel      = w_free & (~w_free + NUM_PIPES'(1));
  assign w_any_free = |w_free;
  assign w_load     = w_spawn ? w_sel : '0;
  assign w_any_pass = |w_pass;

  // Gap top lies in GAP_MIN .. GAP_MIN+127 from the low seven random bits.
  assign w_new_gap = X_W'(GAP_MIN) + X_W'(i_rnd[6:0]);

  // Game state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (i_enable) begin
      case (r_state)
        ST_IDLE:   if (i_start) r_state <= ST_RUN;
        ST_RUN:    if (i_crash) r_state <= ST_FROZEN;
        ST_FROZEN: if (i_start) r_state <= ST_RUN;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Spawn interval counter; wraps on every spawn attempt, dropped or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spawn_cnt <= '0;
    end else if (w_enter_run) begin
      r_spawn_cnt <= '0;
    end else if (w_run_tick) begin
      if (r_spawn_cnt == C_CNT_LAST) begin
        r_spawn_cnt <= '0;
      end else begin
        r_spawn_cnt <= r_spawn_cnt + C_CNT_W'(1);
      end
    end
  end

  // Saturating score of pipes passed this game.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score <= '0;
    end else if (w_enter_run) begin
      r_score <= '0;
    end else if (w_run_tick && w_any_pass && (r_score != 8'hFF)) begin
      r_score <= r_score + 8'd1;
    end
  end

  // One-cycle status pulses, forced low while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_pulse <= 1'b0;
      r_spawn_drop <= 1'b0;
    end else if (!i_enable) begin
      r_pass_pulse <= 1'b0;
      r_spawn_drop <= 1'b0;
    end else begin
      r_pass_pulse <= w_run_tick && w_any_pass;
      r_spawn_drop <= w_spawn && !w_any_free;
    end
  end

  // Pipe slot pool.
  for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_slot
    pipe_slot #(
      .X_W      (X_W),
      .SCREEN_W (SCREEN_W),
      .SPEED    (SPEED),
      .BIRD_X   (BIRD_X)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (w_enter_run),
      .i_scroll   (w_run_tick),
      .i_load     (w_load[gi]),
      .i_load_gap (w_new_gap),
      .o_x        (o_pipe_x[gi*X_W +: X_W]),
      .o_gap      (o_gap_y[gi*X_W +: X_W]),
      .o_valid    (w_valid[gi]),
      .o_pass     (w_pass[gi])
    );
  end

  assign o_pipe_valid = w_valid;
  assign o_pass_pulse = r_pass_pulse;
  assign o_spawn_drop = r_spawn_drop;
  assign o_score      = r_score;
  assign o_state      = r_state;

endmodule : pipe_spawner
`default_nettype wire

// File: tb/tb_pipe_spawner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipe_spawner
// Description : Self-checking bench for pipe_spawner: control vectors from a
//               table, then hand-written spawn/pass/retire/crash/reset and
//               pool-full sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_spawner;

  localparam int NP = 4;
  localparam int XW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            en, tick, start, crash;
  logic [7:0]      rnd;
  logic [NP*XW-1:0] px, gy;
  logic [NP-1:0]   pv;
  logic            pp, sd;
  logic [7:0]      sc;
  logic [1:0]      st;

  pipe_spawner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (en),
    .i_tick       (tick),
    .i_start      (start),
    .i_crash      (crash),
    .i_rnd        (rnd),
    .o_pipe_x     (px),
    .o_gap_y      (gy),
    .o_pipe_valid (pv),
    .o_pass_pulse (pp),
    .o_spawn_drop (sd),
    .o_score      (sc),
    .o_state      (st)
  );

  // Second instance with a short spawn interval to fill the pool.
  logic            d2_tick, d2_start;
  logic [NP*XW-1:0] d2_px, d2_gy;
  logic [NP-1:0]   d2_pv;
  logic            d2_pp, d2_sd;
  logic [7:0]      d2_sc;
  logic [1:0]      d2_st;

  pipe_spawner #(.SPAWN_TICKS(10)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (1'b1),
    .i_tick       (d2_tick),
    .i_start      (d2_start),
    .i_crash      (1'b0),
    .i_rnd        (8'd0),
    .o_pipe_x     (d2_px),
    .o_gap_y      (d2_gy),
    .o_pipe_valid (d2_pv),
    .o_pass_pulse (d2_pp),
    .o_spawn_drop (d2_sd),
    .o_score      (d2_sc),
    .o_state      (d2_st)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [XW-1:0] xo(input int i);
    return px[i*XW +: XW];
  endfunction

  function automatic logic [XW-1:0] go(input int i);
    return gy[i*XW +: XW];
  endfunction

  // Advance one clock; outputs settle 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic       tk;
    logic       st;
    logic       cr;
    logic [1:0] e_state;
    logic [3:0] e_valid;
    logic [7:0] e_score;
  } vec_t;

  vec_t vt[7];

  int pulses;
  int pulse_t;
  int drops;

  initial begin
    en = 1'b1; tick = 1'b0; start = 1'b0; crash = 1'b0; rnd = 8'd0;
    d2_tick = 1'b0; d2_start = 1'b0;

    // en, tick, start, crash -> state, valid, score
    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 8'd0}; // disabled start ignored
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 8'd0}; // crash ignored in IDLE
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 8'd0}; // IDLE -> RUN
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 8'd0}; // disabled crash ignored
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000, 8'd0}; // crash beats start/tick
    vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 8'd0}; // crash ignored in FROZEN
    vt[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 8'd0}; // FROZEN -> RUN

    // Reset values.
    #2;
    chk("reset_state", 32'(st), 32'd0);
    chk("reset_valid", 32'(pv), 32'd0);
    chk("reset_score", 32'(sc), 32'd0);
    chk("reset_x0", 32'(xo(0)), 32'd0);
    chk("reset_pass", 32'(pp), 32'd0);
    chk("reset_drop", 32'(sd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // No start: ticks do nothing.
    tick = 1'b1;
    repeat (200) cyc();
    tick = 1'b0;
    chk("idle_state", 32'(st), 32'd0);
    chk("idle_valid", 32'(pv), 32'd0);
    chk("idle_score", 32'(sc), 32'd0);

    // Control vectors.
    for (int i = 0; i < 7; i++) begin
      en = vt[i].en; tick = vt[i].tk; start = vt[i].st; crash = vt[i].cr;
      cyc();
      en = 1'b1; tick = 1'b0; start = 1'b0; crash = 1'b0;
      chk($sformatf("vec%0d_state", i), 32'(st), 32'(vt[i].e_state));
      chk($sformatf("vec%0d_valid", i), 32'(pv), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d_score", i), 32'(sc), 32'(vt[i].e_score));
    end

    // First spawn on the 90th tick.
    rnd  = 8'd100;
    tick = 1'b1;
    repeat (89) cyc();
    chk("prespawn_valid", 32'(pv), 32'd0);
    cyc();
    tick = 1'b0;
    chk("spawn_valid", 32'(pv), 32'b0001);
    chk("spawn_x0", 32'(xo(0)), 32'd640);
    chk("spawn_gap0", 32'(go(0)), 32'd140);

    // Disabled ticks freeze everything.
    en = 1'b0; tick = 1'b1;
    repeat (3) cyc();
    en = 1'b1; tick = 1'b0;
    chk("freeze_x0", 32'(xo(0)), 32'd640);

    tick = 1'b1;
    repeat (10) cyc();
    tick = 1'b0;
    chk("scroll10_x0", 32'(xo(0)), 32'd620);

    // Ticks 11..240 after spawn: exactly one pass, on tick 240.
    pulses = 0; pulse_t = -1;
    for (int t = 11; t <= 240; t++) begin
      if (t == 100) rnd = 8'd200;
      tick = 1'b1;
      cyc();
      if (pp === 1'b1) begin
        pulses++;
        pulse_t = t;
      end
    end
    tick = 1'b0;
    chk("pass_count", 32'(pulses), 32'd1);
    chk("pass_tick", 32'(pulse_t), 32'd240);
    chk("pass_x0", 32'(xo(0)), 32'd160);
    chk("pass_score", 32'(sc), 32'd1);
    chk("pass_x1", 32'(xo(1)), 32'd340);
    chk("pass_gap1", 32'(go(1)), 32'd140);
    chk("pass_x2", 32'(xo(2)), 32'd520);
    chk("pass_gap2", 32'(go(2)), 32'd112);
    chk("pass_valid", 32'(pv), 32'b0111);
    cyc();
    chk("pass_pulse_end", 32'(pp), 32'd0);

    // Retire slot 0 and reuse it at the next spawn.
    tick = 1'b1;
    repeat (80) cyc();
    chk("edge_x0", 32'(xo(0)), 32'd0);
    chk("edge_valid", 32'(pv), 32'b1111);
    cyc();
    chk("retire_valid", 32'(pv), 32'b1110);
    chk("retire_x0", 32'(xo(0)), 32'd0);
    repeat (39) cyc();
    tick = 1'b0;
    chk("reuse_valid", 32'(pv), 32'b1111);
    chk("reuse_x0", 32'(xo(0)), 32'd640);
    chk("reuse_gap0", 32'(go(0)), 32'd112);
    chk("reuse_x3", 32'(xo(3)), 32'd460);
    chk("reuse_score", 32'(sc), 32'd2);

    // Crash with a simultaneous tick: frozen, nothing moves.
    tick = 1'b1; crash = 1'b1;
    cyc();
    crash = 1'b0;
    chk("crash_state", 32'(st), 32'd2);
    chk("crash_x1", 32'(xo(1)), 32'd100);
    chk("crash_x2", 32'(xo(2)), 32'd280);
    repeat (5) cyc();
    tick = 1'b0;
    chk("frozen_x3", 32'(xo(3)), 32'd460);
    chk("frozen_x0", 32'(xo(0)), 32'd640);
    chk("frozen_score", 32'(sc), 32'd2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_state", 32'(st), 32'd1);
    chk("restart_valid", 32'(pv), 32'd0);
    chk("restart_score", 32'(sc), 32'd0);

    // Asynchronous reset between edges.
    tick = 1'b1;
    repeat (90) cyc();
    tick = 1'b0;
    chk("rerun_valid", 32'(pv), 32'b0001);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(st), 32'd0);
    chk("async_valid", 32'(pv), 32'd0);
    chk("async_x0", 32'(xo(0)), 32'd0);
    chk("async_gap0", 32'(go(0)), 32'd0);
    #10;
    @(negedge clk);
    rst_n = 1'b1;

    // Pool full on the fifth spawn of the short-interval instance.
    d2_start = 1'b1;
    cyc();
    d2_start = 1'b0;
    chk("d2_state", 32'(d2_st), 32'd1);
    drops = 0;
    d2_tick = 1'b1;
    for (int t = 1; t <= 49; t++) begin
      cyc();
      if (d2_sd === 1'b1) drops++;
    end
    chk("d2_nodrop", 32'(drops), 32'd0);
    chk("d2_full", 32'(d2_pv), 32'b1111);
    cyc();
    d2_tick = 1'b0;
    chk("d2_drop", 32'(d2_sd), 32'd1);
    chk("d2_full_after", 32'(d2_pv), 32'b1111);
    cyc();
    chk("d2_drop_end", 32'(d2_sd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pipe_spawner
`default_nettype wire
